dbi_rx_decoder: RTL
===================

DBI_RX_DECODER -- requirements
Module: dbi_rx_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data bus width in bits (little-endian, bit 0 = LSB).
REQ-002 SHALL have parameter CNT_W, default 8, width of the inverted-word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  WIDTH  received bus word, possibly inverted.
REQ-006 SHALL have port in_dbi  input  1  1 = in_data was sent inverted.
REQ-007 SHALL have port in_valid  input  1  upstream word present.
REQ-008 SHALL have port in_ready  output  1  decoder can accept a word this cycle.
REQ-009 SHALL have port out_data  output  WIDTH  restored (decoded) word.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 SHALL have port clr  input  1  synchronous clear of inv_cnt and err.
REQ-013 SHALL have port inv_cnt  output  CNT_W  count of accepted words with in_dbi=1.
REQ-014 SHALL have port err  output  1  sticky DBI-rule violation flag.

Function
REQ-015 SHALL accept a word (push) on a rising edge where in_valid=1 and in_ready=1; a pop SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-016 SHALL decode each pushed word as in_data XOR {WIDTH{in_dbi}} and store the decoded value.
REQ-017 SHALL buffer decoded words in a 2-entry FIFO; out_data SHALL be the oldest entry, out_valid SHALL be 1 iff the FIFO count > 0.
REQ-018 SHALL drive in_ready = 1 iff count < 2, computed from registered state only (no combinational path from out_ready or in_valid to in_ready).
REQ-019 SHALL present a pushed word on out_data with out_valid=1 in the cycle after the push edge (latency 1 cycle) when the FIFO was empty.
REQ-020 SHALL update count per edge: push only +1, pop only -1, push and pop together unchanged with order preserved.
REQ-021 When count=2 and a pop occurs, SHALL accept no push on that edge (in_ready was 0) and SHALL raise in_ready in the next cycle.
REQ-022 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL ignore in_data/in_dbi when in_valid=0 or in_ready=0; no state change from them.
REQ-024 SHALL increment inv_cnt by 1 on each push with in_dbi=1, saturating at 2^CNT_W-1 (no wrap).
REQ-025 SHALL set err on any push whose raw in_data has popcount > WIDTH/2 (encoder rule: transmitted words never exceed half ones); err SHALL stay set until clr or reset.
REQ-026 When clr=1, SHALL set inv_cnt=0 and err=0 on that edge, overriding any same-edge increment or set; clr SHALL NOT affect FIFO contents or handshake.

Reset
REQ-027 On rst_n=0, SHALL immediately (asynchronously) force count=0, out_valid=0, in_ready=0, out_data=0, inv_cnt=0, err=0.
REQ-028 SHALL raise in_ready in the first cycle after rst_n deasserts, synchronous to clk.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered words; no stale word SHALL appear on out_data after reset.

Verification
REQ-030 Push in_data=4'b0001, in_dbi=1 with out_ready=1 -> next cycle out_valid=1, out_data=4'b1110, inv_cnt=1, err=0.
REQ-031 out_ready=0, push 4'b0011/dbi=0 then 4'b0100/dbi=1 -> in_ready=0 after second push; out_data=4'b0011 held; raise out_ready -> pops 4'b0011 then 4'b1011 in order, in_ready=1 the cycle after the first pop.
REQ-032 Push in_data=4'b0111, in_dbi=0 -> err=1 and stays 1 through further legal pushes; pulse clr -> err=0, inv_cnt=0, FIFO contents unchanged.
REQ-033 Push 300 words with in_dbi=1 (CNT_W=8) -> inv_cnt saturates at 255; clr on the same edge as a push with in_dbi=1 -> inv_cnt=0.
REQ-034 Assert rst_n=0 with FIFO count=2 between clock edges -> out_valid, in_ready, inv_cnt, err go to 0 without a clock edge; after release, first push appears on out_data with 1-cycle latency.
REQ-035 Random in_valid/out_ready streaming with in_ready=1 at count=1 (push and pop on same edge) -> count stays 1, output sequence equals input sequence decoded, no loss or duplication.

Source files
------------

// File: rtl/dbi_rx_decoder.sv
// dbi_rx_decoder: DBI word restore into a 2-entry FIFO with inverted-word counter and sticky rule-violation flag
module dbi_rx_decoder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dbi,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr,
    output logic [CNT_W-1:0] inv_cnt,
    output logic             err
);
    logic [WIDTH-1:0] mem [2];
    logic [1:0]       cnt, cnt_nxt;
    logic             rptr, wptr, rdy, push, pop, bad;
    logic [31:0]      ones;
    assign push      = in_valid & rdy;
    assign pop       = (cnt != 2'd0) & out_ready;
    assign cnt_nxt   = cnt + 2'(push) - 2'(pop);
    assign in_ready  = rdy;
    assign out_valid = cnt != 2'd0;
    assign out_data  = out_valid ? mem[rptr] : '0;
    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) ones = ones + 32'(in_data[i]);
        bad = ones > 32'(WIDTH / 2);
    end
    // in_ready is registered from the next count so it never depends on this cycle's handshake inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            rptr    <= 1'b0;
            wptr    <= 1'b0;
            rdy     <= 1'b0;
            mem[0]  <= '0;
            mem[1]  <= '0;
            inv_cnt <= '0;
            err     <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            rdy <= cnt_nxt != 2'd2;
            if (push) begin
                mem[wptr] <= in_data ^ {WIDTH{in_dbi}};
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            if (clr) begin
                inv_cnt <= '0;
                err     <= 1'b0;
            end else begin
                if (push & in_dbi & ~&inv_cnt) inv_cnt <= inv_cnt + CNT_W'(1);
                if (push & bad) err <= 1'b1;
            end
        end
    end
endmodule
